// File: rtl/dbx_decompressor.sv
// DBX symbol decoder: turns a left-aligned bit window into delta bit-planes,
// one symbol per handshake, expanding ZRLE zero runs and XOR-rebuilding planes.
module dbx_decompressor #(
  parameter int DATA_W       = 8,
  parameter int BLOCK_SIZE   = 8,
  parameter int MAX_SYMB_LEN = 8,
  parameter int ZRL_W        = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [MAX_SYMB_LEN-1:0]           in_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  output logic [$clog2(MAX_SYMB_LEN+1)-1:0] in_len_o,
  output logic [BLOCK_SIZE-2:0]             dbp_o,
  output logic [$clog2(DATA_W+1)-1:0]       dbp_idx_o,
  output logic                              dbp_last_o,
  output logic                              dbp_valid_o,
  input  logic                              dbp_ready_i,
  output logic                              err_o
);
  localparam int N     = BLOCK_SIZE - 1;
  localparam int LOG2N = $clog2(N);
  localparam int LEN_W = $clog2(MAX_SYMB_LEN + 1);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam int RUN_W = ZRL_W + 1;
  localparam int M     = MAX_SYMB_LEN;

  typedef enum logic {DECODE, RUN} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [N-1:0]       prev_q;
  logic [RUN_W-1:0]   run_q;
  logic [N-1:0]       dbp_q;
  logic [IDX_W-1:0]   idx_q;
  logic               last_q, vld_q, err_q;

  logic [N-1:0]       dec_plane, emit_plane;
  logic               is_run, ovf, free, acc, emit;
  logic [RUN_W-1:0]   run_len, run_rem;
  logic [LOG2N-1:0]   pos;
  logic [N-1:0]       one_mask, two_mask;

  assign pos      = in_data_i[M-6 -: LOG2N];
  // Out-of-range positions shift the mask off the low end rather than wrapping.
  assign one_mask = {1'b1, {(N-1){1'b0}}} >> pos;
  assign two_mask = {2'b11, {(N-2){1'b0}}} >> pos;
  assign run_len  = RUN_W'(in_data_i[M-4 -: ZRL_W]) + RUN_W'(2);

  always_comb begin
    dec_plane = prev_q;
    in_len_o  = '0;
    is_run    = 1'b0;
    if (in_data_i[M-1]) begin
      dec_plane = prev_q ^ in_data_i[M-2 -: N];
      in_len_o  = LEN_W'(N + 1);
    end else if (in_data_i[M-2]) begin
      in_len_o  = LEN_W'(2);
    end else if (in_data_i[M-3]) begin
      is_run    = 1'b1;
      in_len_o  = LEN_W'(3 + ZRL_W);
    end else begin
      case (in_data_i[M-4 -: 2])
        2'b00: begin dec_plane = ~prev_q;            in_len_o = LEN_W'(5);         end
        2'b01: begin dec_plane = '0;                 in_len_o = LEN_W'(5);         end
        2'b10: begin dec_plane = prev_q ^ two_mask;  in_len_o = LEN_W'(5 + LOG2N); end
        default: begin dec_plane = prev_q ^ one_mask; in_len_o = LEN_W'(5 + LOG2N); end
      endcase
    end
  end

  // A run longer than the planes left in the block is cut off at plane 0.
  assign ovf     = is_run && (int'(run_len) > int'(cnt_q) + 1);
  assign run_rem = ovf ? RUN_W'(cnt_q) : run_len - RUN_W'(1);

  assign free       = !vld_q || dbp_ready_i;
  assign in_ready_o = !rst_i && (state_q == DECODE) && free;
  assign acc        = in_valid_i && in_ready_o;
  assign emit       = (state_q == RUN) ? free : acc;
  assign emit_plane = (state_q == RUN) ? prev_q : dec_plane;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DECODE;
      cnt_q   <= IDX_W'(DATA_W);
      prev_q  <= '0;
      run_q   <= '0;
      dbp_q   <= '0;
      idx_q   <= IDX_W'(DATA_W);
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (emit) begin
        vld_q  <= 1'b1;
        dbp_q  <= emit_plane;
        idx_q  <= cnt_q;
        last_q <= (cnt_q == '0);
        // Slot can only free after the last plane transfers, so wrapping now is safe.
        if (cnt_q == '0) begin
          cnt_q  <= IDX_W'(DATA_W);
          prev_q <= '0;
        end else begin
          cnt_q  <= cnt_q - IDX_W'(1);
          prev_q <= emit_plane;
        end
      end else if (dbp_ready_i) begin
        vld_q <= 1'b0;
      end

      case (state_q)
        DECODE: if (acc && is_run) begin
          if (ovf) err_q <= 1'b1;
          if (run_rem != '0) begin
            run_q   <= run_rem;
            state_q <= RUN;
          end
        end
        default: if (free) begin
          run_q <= run_q - RUN_W'(1);
          if (run_q == RUN_W'(1)) state_q <= DECODE;
        end
      endcase
    end
  end

  assign dbp_o       = dbp_q;
  assign dbp_idx_o   = idx_q;
  assign dbp_last_o  = last_q;
  assign dbp_valid_o = vld_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_dbx_decompressor.sv
// Directed bench for dbx_decompressor with BLOCK_SIZE=8, DATA_W=8, ZRL_W=4.
module tb_dbx_decompressor;
  logic       clk, rst;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [3:0] in_len;
  logic [6:0] dbp;
  logic [3:0] dbp_idx;
  logic       dbp_last, dbp_valid, dbp_ready, err;
  int         errs = 0;
  int         checks = 0;

  dbx_decompressor #(.DATA_W(8), .BLOCK_SIZE(8), .MAX_SYMB_LEN(8), .ZRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_len_o(in_len), .dbp_o(dbp), .dbp_idx_o(dbp_idx),
    .dbp_last_o(dbp_last), .dbp_valid_o(dbp_valid), .dbp_ready_i(dbp_ready), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] p, input logic [3:0] idx,
                         input logic last);
    chk({tag, ".valid"}, dbp_valid, 1'b1);
    chk({tag, ".dbp"}, dbp, p);
    chk({tag, ".idx"}, dbp_idx, idx);
    chk({tag, ".last"}, dbp_last, last);
  endtask

  // Present a symbol, check handshake and length, clock it in.
  task automatic send(input string tag, input logic [7:0] d, input logic [3:0] len);
    in_data = d; in_valid = 1'b1; #1;
    chk({tag, ".ready"}, in_ready, 1'b1);
    chk({tag, ".len"}, in_len, len);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; dbp_ready = 1'b1;
    tick(); tick();
    chk("rst.ready", in_ready, 1'b0);
    chk("rst.valid", dbp_valid, 1'b0);
    chk("rst.dbp", dbp, 7'b0);
    chk("rst.idx", dbp_idx, 4'd8);
    chk("rst.last", dbp_last, 1'b0);
    chk("rst.err", err, 1'b0);
    rst = 1'b0;

    send("raw0", 8'b1_0101010, 4'd8);   chk_out("raw0", 7'b0101010, 4'd8, 1'b0);
    send("ones", 8'b00000_000, 4'd5);   chk_out("ones", 7'b1010101, 4'd7, 1'b0);
    send("single", 8'b00011_010, 4'd8); chk_out("single", 7'b1000101, 4'd6, 1'b0);
    send("run5", 8'b001_0011_0, 4'd7);  chk_out("run5", 7'b1000101, 4'd5, 1'b0);
    in_data = 8'b00001_000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("run5.stall", in_ready, 1'b0);
      tick();
      chk_out("run5.pl", 7'b1000101, 4'(4 - i), 1'b0);
    end
    send("dbxz", 8'b00001_000, 4'd5);   chk_out("dbxz", 7'b0, 4'd0, 1'b1);
    send("raw1", 8'b1_0000001, 4'd8);   chk_out("raw1", 7'b0000001, 4'd8, 1'b0);

    send("ones2", 8'b00000_000, 4'd5);  chk_out("ones2", 7'b1111110, 4'd7, 1'b0);
    send("run2", 8'b001_0000_0, 4'd7);  chk_out("run2", 7'b1111110, 4'd6, 1'b0);
    in_data = 8'b00010_001;
    #1 chk("run2.stall", in_ready, 1'b0);
    tick();                             chk_out("run2.pl", 7'b1111110, 4'd5, 1'b0);
    send("two", 8'b00010_001, 4'd8);    chk_out("two", 7'b1001110, 4'd4, 1'b0);
    send("zs", 8'b01_000000, 4'd2);     chk_out("zs", 7'b1001110, 4'd3, 1'b0);
    send("sgl6", 8'b00011_110, 4'd8);   chk_out("sgl6", 7'b1001111, 4'd2, 1'b0);
    chk("pre_ovf.err", err, 1'b0);
    send("ovf", 8'b001_0010_0, 4'd7);   chk_out("ovf", 7'b1001111, 4'd1, 1'b0);
    chk("ovf.err", err, 1'b1);
    in_data = 8'b1_0000001;
    #1 chk("ovf.stall", in_ready, 1'b0);
    tick();                             chk_out("ovf.pl", 7'b1001111, 4'd0, 1'b1);
    send("raw2", 8'b1_0000001, 4'd8);   chk_out("raw2", 7'b0000001, 4'd8, 1'b0);
    chk("raw2.err", err, 1'b1);

    dbp_ready = 1'b0; in_data = 8'b1_1100000;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.ready", in_ready, 1'b0);
      tick();
      chk_out("bp.hold", 7'b0000001, 4'd8, 1'b0);
    end
    dbp_ready = 1'b1;
    send("bp.rel", 8'b1_1100000, 4'd8); chk_out("bp.rel", 7'b1100001, 4'd7, 1'b0);

    send("run_rst", 8'b001_0011_0, 4'd7); chk_out("run_rst", 7'b1100001, 4'd6, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    #1 chk("rst2.ready", in_ready, 1'b0);
    tick();
    chk("rst2.valid", dbp_valid, 1'b0);
    chk("rst2.idx", dbp_idx, 4'd8);
    chk("rst2.err", err, 1'b0);
    rst = 1'b0;
    send("raw3", 8'b1_0101010, 4'd8);   chk_out("raw3", 7'b0101010, 4'd8, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("drain.valid", dbp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
